display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter N, default 14: width of each display value (0..9999 decimal range).
REQ-002 Parameter NREQ, default 3: number of requesters; legal range 2..8.
REQ-003 Parameter HOLD_CYCLES, default 100_000_000: minimum show time per grant (1 s at 100 MHz).
REQ-004 Parameter BLANK_CYCLES, default 1_000_000: blank gap between different owners (10 ms).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NREQ  per-requester level request; bit i high = requester i wants the display.
REQ-009 val_in  input  NREQ*N  packed values; requester i occupies bits [i*N +: N].
REQ-010 grant  output  NREQ  one-hot owner indication, registered; all-zero when no owner.
REQ-011 disp_value  output  N  value driven into the display module, registered.
REQ-012 disp_blank  output  1  registered; high = display shall show nothing.

Function
REQ-013 States SHALL be IDLE, SHOW and GAP.
REQ-014 IDLE: grant=0, disp_blank=1, disp_value holds its last value; any req bit high at a rising edge SHALL move to SHOW with grant asserted after that same edge (1-cycle latency).
REQ-015 Owner selection SHALL be round-robin: search starts at (last owner + 1) mod NREQ and wraps; after reset the search starts at requester 0.
REQ-016 SHOW: grant one-hot to owner, disp_blank=0, disp_value SHALL track val_in of the owner with one register stage (live update every cycle).
REQ-017 SHOW SHALL last exactly HOLD_CYCLES cycles counted from the first cycle grant is high, unless REQ-019 applies.
REQ-018 At SHOW expiry: another requester high -> GAP; only the owner high -> restart hold timer, stay in SHOW, no blank; no requester high -> IDLE.
REQ-019 Owner dropping req mid-SHOW SHALL end SHOW at the next edge: -> GAP if any other req high, else -> IDLE.
REQ-020 GAP: grant=0, disp_blank=1, exactly BLANK_CYCLES cycles; after the last GAP cycle, arbitrate per REQ-015 and enter SHOW (new grant visible next cycle), or IDLE if no req high.
REQ-021 Requests rising or falling during GAP SHALL only be sampled at GAP end.
REQ-022 Hold/blank counter width SHALL be clog2(max(HOLD_CYCLES,BLANK_CYCLES)+1); no wrap before terminal count.
REQ-023 grant SHALL never have more than one bit set; grant and disp_blank SHALL never both be active.

Reset
REQ-024 While rst_n low: state=IDLE, grant=0, disp_value=0, disp_blank=1, counter=0, round-robin pointer selects requester 0 first.
REQ-025 Reset asserted mid-SHOW or mid-GAP SHALL force REQ-024 values immediately, without waiting for a clock edge; operation resumes at the first edge after release.

Structure
REQ-026 State encoding and default timing constants SHALL live in shared package display_pkg, reused by display and later display controllers.
REQ-027 The round-robin search SHALL be a combinational sub-module rr_picker (inputs req, start pointer; outputs one-hot pick and valid).
REQ-028 disp_value and disp_blank SHALL connect directly to the display module's value input and a blanking gate; no decimal conversion in this block.

Verification (HOLD_CYCLES=8, BLANK_CYCLES=2, NREQ=3, N=14)
REQ-029 Reset release, req=000 for 20 cycles -> grant=000, disp_blank=1, disp_value=0 throughout.
REQ-030 req=010, val1=1234 -> grant=010 one cycle later, disp_value=1234 next cycle, disp_blank=0; held continuously past 8 cycles (timer restarts, no blank).
REQ-031 req=111 from reset -> grants 001 (8 cycles), blank 2 cycles, 010 (8), blank 2, 100 (8), blank 2, 001 again.
REQ-032 Owner 0 drops req at SHOW cycle 3 with req2 high -> GAP next cycle for 2 cycles, then grant=100.
REQ-033 rst_n pulsed low mid-SHOW (owner 1) -> grant=000, disp_blank=1, disp_value=0 asynchronously; with req=011 after release, first grant=001.
REQ-034 val_in of owner changes 42 -> 43 mid-SHOW -> disp_value=43 one cycle later, grant unchanged.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared state encoding, default timing constants and helpers for
//             the display arbiter and later display controllers.
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Arbiter state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_show = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;

    // Default timing at 100 MHz: 1 s show time, 10 ms blank gap
    localparam int c_default_hold_cycles  = 100_000_000;
    localparam int c_default_blank_cycles = 1_000_000;

    // Larger of two integers, used when sizing shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin search. Scans req starting at index
//             'start' and wrapping; returns the first hit one-hot plus valid.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 3,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] start,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    int w_idx;

    // Walk the requesters from 'start' onward, keep the first one found
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(start) + k;
            // start is always < NREQ in use; a second fold keeps it safe anyway
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!valid && req[w_idx[PTRW-1:0]]) begin
                pick[w_idx[PTRW-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : display_arbiter
//  Purpose  : Round-robin arbitration of several requesters for one numeric
//             display. Each grant is held for HOLD_CYCLES, and a blank gap of
//             BLANK_CYCLES separates different owners.
//  Revision : 1.0 - initial release
// ============================================================================
module display_arbiter
    import display_pkg::*;
#(
    parameter int N            = 14,
    parameter int NREQ         = 3,
    parameter int HOLD_CYCLES  = c_default_hold_cycles,
    parameter int BLANK_CYCLES = c_default_blank_cycles
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   val_in,
    output logic [NREQ-1:0]     grant,
    output logic [N-1:0]        disp_value,
    output logic                disp_blank
);

    localparam int c_ptrw = $clog2(NREQ);
    localparam int c_cw   = $clog2(max_int(HOLD_CYCLES, BLANK_CYCLES) + 1);

    // Counters run down to zero, so loads are "cycles minus one"
    localparam logic [c_cw-1:0]   c_hold_load  = c_cw'(HOLD_CYCLES - 1);
    localparam logic [c_cw-1:0]   c_blank_load = c_cw'(BLANK_CYCLES - 1);
    localparam logic [c_cw-1:0]   c_cnt_one    = c_cw'(1);
    localparam logic [c_ptrw-1:0] c_last_idx   = c_ptrw'(NREQ - 1);
    localparam logic [c_ptrw-1:0] c_ptr_one    = c_ptrw'(1);

    logic [1:0]        r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [c_ptrw-1:0] r_ptr;
    logic [c_ptrw-1:0] r_owner;

    logic [1:0]        w_next_state;
    logic              w_take;
    logic              w_restart;
    logic [NREQ-1:0]   w_pick;
    logic              w_pick_valid;
    logic [c_ptrw-1:0] w_pick_idx;
    logic [c_ptrw-1:0] w_sel_idx;
    logic              w_owner_req;
    logic              w_other_req;
    logic              w_cnt_zero;
    logic [N-1:0]      w_vals [NREQ];

    // Split the packed value bus into one word per requester
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_vals[gi] = val_in[gi*N +: N];
    end

    rr_picker #(
        .NREQ (NREQ),
        .PTRW (c_ptrw)
    ) u_rr_picker (
        .req   (req),
        .start (r_ptr),
        .pick  (w_pick),
        .valid (w_pick_valid)
    );

    // grant is the registered owner one-hot, so it masks the owner out here
    assign w_owner_req = req[r_owner];
    assign w_other_req = |(req & ~grant);
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_sel_idx   = w_take ? w_pick_idx : r_owner;

    // Encode the picker's one-hot result as an index
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) w_pick_idx = c_ptrw'(i);
        end
    end

    // Next-state decision: w_take starts a fresh grant, w_restart re-arms SHOW
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_pick_valid) begin
                    w_next_state = c_st_show;
                    w_take       = 1'b1;
                end
            end
            c_st_show: begin
                // Leave early when the owner lets go, otherwise decide at expiry
                if (!w_owner_req || w_cnt_zero) begin
                    if (w_other_req) begin
                        w_next_state = c_st_gap;
                    end else if (w_owner_req) begin
                        w_restart = 1'b1;
                    end else begin
                        w_next_state = c_st_idle;
                    end
                end
            end
            c_st_gap: begin
                // Requests are only looked at once the gap has fully elapsed
                if (w_cnt_zero) begin
                    if (w_pick_valid) begin
                        w_next_state = c_st_show;
                        w_take       = 1'b1;
                    end else begin
                        w_next_state = c_st_idle;
                    end
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // State, hold/blank counter, owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_take || w_restart) begin
                r_cnt <= c_hold_load;
            end else if (w_next_state == c_st_gap && r_state == c_st_show) begin
                r_cnt <= c_blank_load;
            end else if (w_next_state == c_st_idle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            if (w_take) begin
                r_owner <= w_pick_idx;
                r_ptr   <= (w_pick_idx == c_last_idx) ? '0 : w_pick_idx + c_ptr_one;
            end
        end
    end

    // Registered display outputs; the value follows the owner live during SHOW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            disp_value <= '0;
            disp_blank <= 1'b1;
        end else if (w_next_state == c_st_show) begin
            if (w_take) grant <= w_pick;
            disp_blank <= 1'b0;
            disp_value <= w_vals[w_sel_idx];
        end else begin
            grant      <= '0;
            disp_blank <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_arbiter
//  Purpose  : Self-checking bench for display_arbiter with a small timing
//             configuration, directed scenarios and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int N     = 14;
    localparam int NREQ  = 3;
    localparam int HOLD  = 8;
    localparam int BLANK = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] val_in;
    logic [NREQ-1:0]   grant;
    logic [N-1:0]      disp_value;
    logic              disp_blank;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the display and how long each phase has left
    int           m_owner;
    int           m_show_left;
    int           m_gap_left;
    int           m_start;
    logic [N-1:0] m_value;

    display_arbiter #(
        .N            (N),
        .NREQ         (NREQ),
        .HOLD_CYCLES  (HOLD),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .val_in     (val_in),
        .grant      (grant),
        .disp_value (disp_value),
        .disp_blank (disp_blank)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] value_of(input int i);
        return val_in[i*N +: N];
    endfunction

    task automatic set_val(input int i, input int v);
        val_in[i*N +: N] = N'(v);
    endtask

    task automatic model_reset();
        m_owner     = 0;
        m_show_left = 0;
        m_gap_left  = 0;
        m_start     = 0;
        m_value     = '0;
    endtask

    task automatic model_try_grant(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_start + k) % NREQ;
            if (r[idx]) begin
                m_owner     = idx;
                m_show_left = HOLD;
                m_value     = value_of(idx);
                m_start     = (idx + 1) % NREQ;
                return;
            end
        end
    endtask

    // One rising edge of the arbitration rules, using inputs seen at that edge
    task automatic model_step();
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] others;
        r = req;
        if (m_show_left > 0) begin
            others = r & ~(NREQ'(1) << m_owner);
            if (!r[m_owner] || m_show_left == 1) begin
                if (others != '0) begin
                    m_show_left = 0;
                    m_gap_left  = BLANK;
                end else if (r[m_owner]) begin
                    m_show_left = HOLD;
                end else begin
                    m_show_left = 0;
                end
            end else begin
                m_show_left--;
            end
            if (m_show_left > 0) m_value = value_of(m_owner);
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) model_try_grant(r);
        end else begin
            model_try_grant(r);
        end
    endtask

    task automatic compare_outputs();
        logic [NREQ-1:0] exp_grant;
        exp_grant = (m_show_left > 0) ? (NREQ'(1) << m_owner) : '0;
        check_value("grant", 32'(grant), 32'(exp_grant));
        check_value("disp_blank", 32'(disp_blank), 32'(m_show_left == 0));
        check_value("disp_value", 32'(disp_value), 32'(m_value));
        check_value("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        check_value("grant_blank_excl", 32'((grant != '0) && disp_blank), 32'd0);
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Pulse reset between clock edges and confirm it takes effect without one
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        val_in = '0;
        model_reset();
        @(negedge clk);
        compare_outputs();
        #1 rst_n = 1'b1;

        // Idle with no requests
        run_cycles(20);

        // Single requester holds past its show time without a blank
        set_val(1, 1234);
        req = 3'b010;
        run_cycle();
        check_value("single_first_grant", 32'(grant), 32'd2);
        check_value("single_first_value", 32'(disp_value), 32'd1234);
        run_cycles(20);
        check_value("single_still_owner", 32'(grant), 32'd2);

        // All three requesting rotates 0 -> 1 -> 2 -> 0
        async_reset();
        set_val(0, 11); set_val(1, 22); set_val(2, 33);
        req = 3'b111;
        run_cycles(3 * (HOLD + BLANK) + 2);
        check_value("rotate_back_to_0", 32'(grant), 32'd1);

        // Owner 0 drops mid-show while requester 2 waits
        async_reset();
        req = 3'b101;
        run_cycles(3);
        req = 3'b100;
        run_cycles(BLANK + 1);
        check_value("drop_then_grant2", 32'(grant), 32'd4);

        // Reset mid-show of owner 1, then arbitration restarts at requester 0
        async_reset();
        req = 3'b010;
        run_cycles(4);
        async_reset();
        req = 3'b011;
        run_cycle();
        check_value("post_reset_grant", 32'(grant), 32'd1);

        // Live value tracking of the owner
        async_reset();
        set_val(0, 42);
        req = 3'b001;
        run_cycles(3);
        set_val(0, 43);
        run_cycle();
        check_value("live_value", 32'(disp_value), 32'd43);
        check_value("live_grant", 32'(grant), 32'd1);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0)
                set_val(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 199) == 0) async_reset();
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
